// File: rtl/a5_pkg.sv
// ---------------------------------------------------------------------------
// a5_pkg
// Shared definitions for the A5/1 session controller:
//   - session FSM state type
//   - LFSR lengths, tap masks and clocking-bit positions
//   - phase lengths and the matching last-count values for the step counter
//   - maj3 helper used by the majority clocking rule
// No ports (package).
// ---------------------------------------------------------------------------
package a5_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOAD_KEY   = 3'd1,
    ST_LOAD_FRAME = 3'd2,
    ST_WARMUP     = 3'd3,
    ST_GEN        = 3'd4,
    ST_FLUSH      = 3'd5
  } state_e;

  // Phase lengths
  localparam int unsigned KEY_W   = 64;
  localparam int unsigned FRAME_W = 22;
  localparam int unsigned WARMUP  = 100;
  localparam int unsigned KS_BITS = 228;

  // Register lengths
  localparam int unsigned LEN_A = 19;
  localparam int unsigned LEN_B = 22;
  localparam int unsigned LEN_C = 23;

  // Tap masks: feedback is the XOR of the masked register bits
  localparam logic [LEN_A-1:0] TAP_A = 19'h72000;   // 18,17,16,13
  localparam logic [LEN_B-1:0] TAP_B = 22'h300000;  // 21,20
  localparam logic [LEN_C-1:0] TAP_C = 23'h700080;  // 22,21,20,7

  // Clocking-bit positions for the majority rule
  localparam int unsigned CLK_A = 8;
  localparam int unsigned CLK_B = 10;
  localparam int unsigned CLK_C = 10;

  // Shared step counter: wide enough for the longest phase (228)
  localparam int unsigned CNT_W = 9;
  localparam logic [CNT_W-1:0] CNT_KEY_LAST   = CNT_W'(KEY_W - 1);
  localparam logic [CNT_W-1:0] CNT_FRAME_LAST = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] CNT_WARM_LAST  = CNT_W'(WARMUP - 1);
  localparam logic [CNT_W-1:0] CNT_GEN_LAST   = CNT_W'(KS_BITS - 1);

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/a5_session_ctrl_if.sv
// ---------------------------------------------------------------------------
// a5_session_ctrl_if
// Session control and keystream byte stream of the A5/1 session controller.
//   start    : session request (master -> slave)
//   key      : 64-bit session key, captured on accepted start
//   frame    : 22-bit frame number, captured on accepted start
//   busy     : session in progress (slave -> master)
//   done     : one-cycle pulse after the final byte handshake
//   ks_data  : keystream byte, first generated bit in bit 7
//   ks_valid : ks_data valid
//   ks_ready : downstream accept (master -> slave)
//   ks_last  : final byte of the session
//   ks_nbits : number of valid bits in ks_data (8, or 4 on the last byte)
// ---------------------------------------------------------------------------
interface a5_session_ctrl_if;
  import a5_pkg::*;

  logic               start;
  logic [KEY_W-1:0]   key;
  logic [FRAME_W-1:0] frame;
  logic               busy;
  logic               done;
  logic [7:0]         ks_data;
  logic               ks_valid;
  logic               ks_ready;
  logic               ks_last;
  logic [3:0]         ks_nbits;

  modport master (
    output start, key, frame, ks_ready,
    input  busy, done, ks_data, ks_valid, ks_last, ks_nbits
  );

  modport slave (
    input  start, key, frame, ks_ready,
    output busy, done, ks_data, ks_valid, ks_last, ks_nbits
  );

endinterface

// File: rtl/a5_lfsr_core.sv
// ---------------------------------------------------------------------------
// a5_lfsr_core
// The three A5/1 shift registers (19/22/23 bits).
//   clk        : clock, rising edge
//   rest       : synchronous active-low reset, clears all registers
//   clr_i      : clear all registers
//   step_all_i : load mode, every register steps, inj_bit_i XORed into feedback
//   step_maj_i : majority mode, registers whose clocking bit matches the
//                majority step
//   inj_bit_i  : key/frame bit injected in load mode
//   ks_bit_o   : output bit of the state reached by a majority step taken
//                this cycle (lookahead, so a captured bit matches the step
//                committed at the same edge)
// ---------------------------------------------------------------------------
module a5_lfsr_core
  import a5_pkg::*;
(
  input  logic clk,
  input  logic rest,
  input  logic clr_i,
  input  logic step_all_i,
  input  logic step_maj_i,
  input  logic inj_bit_i,
  output logic ks_bit_o
);

  logic [LEN_A-1:0] a_q, a_d, a_maj_s;
  logic [LEN_B-1:0] b_q, b_d, b_maj_s;
  logic [LEN_C-1:0] c_q, c_d, c_maj_s;
  logic             fb_a_s, fb_b_s, fb_c_s;
  logic             maj_s;

  // Feedback, majority-step lookahead and next-state selection
  always_comb begin
    fb_a_s = ^(a_q & TAP_A);
    fb_b_s = ^(b_q & TAP_B);
    fb_c_s = ^(c_q & TAP_C);
    maj_s  = maj3(a_q[CLK_A], b_q[CLK_B], c_q[CLK_C]);

    if (a_q[CLK_A] == maj_s) begin
      a_maj_s = {a_q[LEN_A-2:0], fb_a_s};
    end else begin
      a_maj_s = a_q;
    end
    if (b_q[CLK_B] == maj_s) begin
      b_maj_s = {b_q[LEN_B-2:0], fb_b_s};
    end else begin
      b_maj_s = b_q;
    end
    if (c_q[CLK_C] == maj_s) begin
      c_maj_s = {c_q[LEN_C-2:0], fb_c_s};
    end else begin
      c_maj_s = c_q;
    end

    ks_bit_o = a_maj_s[LEN_A-1] ^ b_maj_s[LEN_B-1] ^ c_maj_s[LEN_C-1];

    if (clr_i) begin
      a_d = {LEN_A{1'b0}};
      b_d = {LEN_B{1'b0}};
      c_d = {LEN_C{1'b0}};
    end else if (step_all_i) begin
      a_d = {a_q[LEN_A-2:0], fb_a_s ^ inj_bit_i};
      b_d = {b_q[LEN_B-2:0], fb_b_s ^ inj_bit_i};
      c_d = {c_q[LEN_C-2:0], fb_c_s ^ inj_bit_i};
    end else if (step_maj_i) begin
      a_d = a_maj_s;
      b_d = b_maj_s;
      c_d = c_maj_s;
    end else begin
      a_d = a_q;
      b_d = b_q;
      c_d = c_q;
    end
  end

  // Register state
  always_ff @(posedge clk) begin
    if (!rest) begin
      a_q <= {LEN_A{1'b0}};
      b_q <= {LEN_B{1'b0}};
      c_q <= {LEN_C{1'b0}};
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      c_q <= c_d;
    end
  end

endmodule

// File: rtl/a5_session_ctrl.sv
// ---------------------------------------------------------------------------
// a5_session_ctrl
// Runs one A5/1 session: clear, 64 key-load steps, 22 frame-load steps,
// 100 discarded warm-up steps, then 228 keystream bits packed MSB-first into
// bytes on a valid/ready stream (last byte carries 4 bits, left-aligned).
//   clk  : clock, rising edge
//   rest : synchronous active-low reset; abandons any session, no done
//   bus  : a5_session_ctrl_if.slave (start/key/frame in, busy/done out,
//          ks_data/ks_valid/ks_last/ks_nbits out, ks_ready in)
// ---------------------------------------------------------------------------
module a5_session_ctrl
  import a5_pkg::*;
(
  input  logic              clk,
  input  logic              rest,
  a5_session_ctrl_if.slave  bus
);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [KEY_W-1:0]   key_q;
  logic [FRAME_W-1:0] frame_q;
  logic [6:0]         pk_q;
  logic [7:0]         data_q;
  logic               valid_q;
  logic               last_q;
  logic [3:0]         nbits_q;
  logic               busy_q;
  logic               done_q;

  logic accept_s, room_s, last_bit_s, byte_end_s, gen_go_s;
  logic clr_s, step_all_s, step_maj_s, inj_s, ks_bit_s;

  a5_lfsr_core u_core (
    .clk        (clk),
    .rest       (rest),
    .clr_i      (clr_s),
    .step_all_i (step_all_s),
    .step_maj_i (step_maj_s),
    .inj_bit_i  (inj_s),
    .ks_bit_o   (ks_bit_s)
  );

  // Handshake, stall decision and core control decode
  always_comb begin
    accept_s   = valid_q & bus.ks_ready;
    room_s     = ~valid_q | bus.ks_ready;
    last_bit_s = (cnt_q == CNT_GEN_LAST);
    byte_end_s = (cnt_q[2:0] == 3'd7) | last_bit_s;
    // GEN only stalls on the cycle that would hand a byte to a full register
    gen_go_s   = (state_q == ST_GEN) & (~byte_end_s | room_s);
    clr_s      = (state_q == ST_IDLE) & bus.start;
    step_all_s = (state_q == ST_LOAD_KEY) | (state_q == ST_LOAD_FRAME);
    step_maj_s = (state_q == ST_WARMUP) | gen_go_s;
    // key/frame registers shift right, so bit 0 is always the next LSB-first bit
    if (state_q == ST_LOAD_KEY) begin
      inj_s = key_q[0];
    end else if (state_q == ST_LOAD_FRAME) begin
      inj_s = frame_q[0];
    end else begin
      inj_s = 1'b0;
    end
  end

  // Session FSM, step counter, bit packer and output register
  always_ff @(posedge clk) begin
    if (!rest) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      key_q   <= {KEY_W{1'b0}};
      frame_q <= {FRAME_W{1'b0}};
      pk_q    <= 7'd0;
      data_q  <= 8'd0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      nbits_q <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;

      // Drain first; a load later in this block overrides it (same-cycle refill)
      if (accept_s) begin
        valid_q <= 1'b0;
        data_q  <= 8'd0;
        last_q  <= 1'b0;
        nbits_q <= 4'd0;
      end

      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            key_q   <= bus.key;
            frame_q <= bus.frame;
            cnt_q   <= {CNT_W{1'b0}};
            pk_q    <= 7'd0;
            busy_q  <= 1'b1;
            state_q <= ST_LOAD_KEY;
          end
        end

        ST_LOAD_KEY: begin
          key_q <= {1'b0, key_q[KEY_W-1:1]};
          if (cnt_q == CNT_KEY_LAST) begin
            cnt_q   <= {CNT_W{1'b0}};
            state_q <= ST_LOAD_FRAME;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        ST_LOAD_FRAME: begin
          frame_q <= {1'b0, frame_q[FRAME_W-1:1]};
          if (cnt_q == CNT_FRAME_LAST) begin
            cnt_q   <= {CNT_W{1'b0}};
            state_q <= ST_WARMUP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        ST_WARMUP: begin
          if (cnt_q == CNT_WARM_LAST) begin
            cnt_q   <= {CNT_W{1'b0}};
            state_q <= ST_GEN;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        ST_GEN: begin
          if (gen_go_s) begin
            if (byte_end_s) begin
              // The bit produced this cycle goes straight into the byte,
              // saving a cycle of packer-to-register latency
              valid_q <= 1'b1;
              last_q  <= last_bit_s;
              pk_q    <= 7'd0;
              if (last_bit_s) begin
                data_q  <= {pk_q[2:0], ks_bit_s, 4'b0000};
                nbits_q <= 4'd4;
              end else begin
                data_q  <= {pk_q, ks_bit_s};
                nbits_q <= 4'd8;
              end
            end else begin
              pk_q <= {pk_q[5:0], ks_bit_s};
            end
            if (last_bit_s) begin
              cnt_q   <= {CNT_W{1'b0}};
              state_q <= ST_FLUSH;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end

        ST_FLUSH: begin
          // Stay here through the done cycle so a start there is ignored
          if (done_q) begin
            state_q <= ST_IDLE;
          end else if (accept_s & last_q) begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.ks_data  = data_q;
  assign bus.ks_valid = valid_q;
  assign bus.ks_last  = last_q;
  assign bus.ks_nbits = nbits_q;

endmodule

// File: doc/a5_session_ctrl.md
Name: a5_session_ctrl

Overview:
Sequences one complete A5/1 keystream session around an internal three-LFSR core. A session runs in this order: clear, key load, frame-number load, 100-step warm-up, then 228 keystream bits. The bits are packed MSB-first into bytes and delivered over a valid/ready stream with backpressure. This block replaces free-running keystream generation so upstream logic sees only start/busy/done and a byte stream.

Parameters:
KEY_W, 64, session key width (bits loaded LSB first)
FRAME_W, 22, frame-number width (bits loaded LSB first)
WARMUP, 100, majority-clocked steps with output discarded
KS_BITS, 228, keystream bits delivered per session

Ports:
clk  in  1  clock, rising edge
rest  in  1  reset, synchronous, active-low
start  in  1  session request; sampled only in IDLE
key  in  64  session key; captured on accepted start
frame  in  22  frame number; captured on accepted start
busy  out  1  high from the cycle after accepted start until done
done  out  1  one-cycle pulse after the final byte handshake
ks_data  out  8  keystream byte; first generated bit in bit 7
ks_valid  out  1  ks_data valid
ks_ready  in  1  downstream accept
ks_last  out  1  marks the final byte of the session
ks_nbits  out  4  valid bits in ks_data (8, or 4 on the last byte)

Behaviour:
- Reset (rest=0 at a clk edge) wins over everything:
  - state returns to IDLE, LFSRs are cleared, the output register is emptied;
  - busy, done, ks_valid, ks_last are 0; ks_data and ks_nbits are 0.
  - Reset mid-session abandons it; no done pulse is produced.
- LFSR core, using the team's tap set:
  - A: 19 bits, taps 18,17,16,13, clocking bit A[8].
  - B: 22 bits, taps 21,20, clocking bit B[10].
  - C: 23 bits, taps 22,21,20,7, clocking bit C[10].
  - A step shifts left and places feedback in the LSB.
  - Output bit = A[18]^B[21]^C[22].
- States: IDLE, LOAD_KEY, LOAD_FRAME, WARMUP, GEN, FLUSH.
- IDLE: start=1 latches key and frame, zeroes all LFSRs, and goes to LOAD_KEY. Cycle of start = cycle 0.
- LOAD_KEY, cycles 1..64:
  - all three registers step every cycle (no majority rule);
  - new LSB = feedback ^ key[i], with i = cycle-1.
- LOAD_FRAME, cycles 65..86: same rule using frame[i], i = 0..21.
- WARMUP, cycles 87..186: majority-clocked steps; output is discarded.
  - Majority m = maj(A[8],B[10],C[10]).
  - Each register steps iff its clocking bit == m, so at least two registers step.
- GEN, from cycle 187: one majority step per non-stalled cycle.
  - Keystream bit k is the output bit of the state after step 101+k.
  - Bits shift into an 8-bit packer, MSB first.
- Output register:
  - A full packer (8 bits), or the final 4 bits, transfers to the output register when that register is empty or is being accepted in the same cycle.
  - Otherwise GEN stalls: no LFSR step and no bit count.
  - The final byte is left-aligned (bits 7:4) with zeros in bits 3:0, ks_nbits=4, ks_last=1.
- Handshake:
  - Transfer occurs when ks_valid & ks_ready.
  - ks_data, ks_last, ks_nbits stay stable while ks_valid=1 and ks_ready=0.
  - ks_valid never drops without a transfer, except on reset.
- Timing with ks_ready held at 1: byte n (0..27) is valid in cycle 195+8n; the last byte is valid in cycle 415.
- After the 228th bit the FSM enters FLUSH. It waits for the last-byte handshake, then pulses done for one cycle and returns to IDLE.
  - busy=0 in the same cycle done=1.
  - start in that cycle is ignored; start is accepted from the next cycle.
- start while busy is ignored; key and frame changes while busy have no effect.
- Counters: one shared 9-bit step counter (max 228). Each phase reloads it; no wrap beyond a phase.

Decomposition:
- Package a5_pkg holds:
  - state enum;
  - register lengths 19/22/23;
  - tap positions and clocking-bit indices;
  - phase lengths (64/22/100/228);
  - function maj3.
- Sub-module a5_lfsr_core contains the three registers. Its inputs:
  - clr;
  - step_all (load mode);
  - step_maj (majority mode);
  - inj_bit (XORed into all feedbacks in load mode).
  Its output is ks_bit.
- The controller holds the FSM, counter, packer and output register.

Test Plan:
- key=0, frame=0, ks_ready=1:
  - the LFSRs stay zero;
  - 29 bytes of 0x00, bytes 0..27 with ks_nbits=8, byte 28 with ks_nbits=4 and ks_last=1;
  - first valid in cycle 195, done in cycle 416.
- key=64'h0123456789ABCDEF, frame=22'h134, ks_ready=1 → all 228 bits match the bit-accurate C model of this spec; last byte low nibble = 0.
- Same vector, ks_ready random at 30% duty → identical byte sequence; ks_data stable during every stall; done exactly once.
- Pulse start again at cycles 10 and 300 of a session → ignored; output identical to the single-start run; busy stays high.
- Drive rest=0 for one cycle during GEN at cycle 250 → next cycle all outputs 0, state IDLE, no done; a fresh start gives the full correct session.
- Hold ks_ready=0 from cycle 190 to 600 → ks_valid stays high on byte 0; the LFSRs freeze after at most 8 further bits; releasing ks_ready resumes with no lost or duplicated bits.
